// File: rtl/sdram_size_probe.sv
// Power-up SDRAM sizing sequencer: aliasing write/read-back probe publishes cfg,
// then a paced zero-fill sweep of the array. Owns the controller command port.
module sdram_size_probe #(
  parameter int CLR_AW  = 25,
  parameter int CLR_GAP = 32
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              sdram_ready,
  input  logic [15:0]       sdram_dout,
  output logic [26:0]       sdram_addr,
  output logic [15:0]       sdram_din,
  output logic              sdram_we,
  output logic              sdram_rd,
  output logic [15:0]       cfg,
  output logic [CLR_AW-1:0] clr_addr,
  output logic              clr_done
);

  // state    | meaning
  // WAIT_RDY | wait for controller init, then issue W4
  // W4..W1   | probe writes (issue / settle / wait-ready)
  // R4..R0   | probe reads, result sampled on completion
  // CLEAR    | paced zero writes over 0 .. 2^CLR_AW-1
  // DONE     | idle until RESET
  typedef enum logic [3:0] {
    S_WAIT_RDY, S_W4, S_W2, S_W0, S_W1, S_R4, S_R2, S_R0, S_CLEAR, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_ISSUE, PH_SETTLE, PH_WAIT} phase_t;

  localparam logic [26:0] A4 = 27'h4000000;
  localparam logic [26:0] A2 = 27'h2000000;
  localparam logic [26:0] A1 = 27'h1000000;
  localparam logic [26:0] A0 = 27'h0000000;
  localparam logic [15:0] D4 = 16'd3128;
  localparam logic [15:0] D2 = 16'd2064;
  localparam logic [15:0] D0 = 16'd1032;
  localparam logic [15:0] D1 = 16'd12345;
  localparam logic [7:0]  GAP_M1 = 8'(CLR_GAP - 1);

  state_t              r_state, w_state_nx, w_seq_nx;
  phase_t              r_phase, w_phase_nx;
  logic [26:0]         r_addr, w_addr_nx;
  logic [15:0]         r_din, w_din_nx;
  logic                r_we, w_we_nx;
  logic                r_rd, w_rd_nx;
  logic [15:0]         r_cfg, w_cfg_nx;
  logic [7:0]          r_cnt, w_cnt_nx;
  logic [CLR_AW-1:0]   r_clr_addr, w_clr_addr_nx;
  logic                r_last, w_last_nx;
  logic                r_clr_done, w_clr_done_nx;
  logic                w_acc_done;
  logic                w_expire;

  assign w_acc_done = (r_phase == PH_WAIT) && sdram_ready;
  assign w_expire   = (r_cnt == GAP_M1);

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_state    <= S_WAIT_RDY;
      r_phase    <= PH_ISSUE;
      r_addr     <= 27'd0;
      r_din      <= 16'd0;
      r_we       <= 1'b0;
      r_rd       <= 1'b0;
      r_cfg      <= 16'd0;
      r_cnt      <= 8'd0;
      r_clr_addr <= '0;
      r_last     <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_phase    <= w_phase_nx;
      r_addr     <= w_addr_nx;
      r_din      <= w_din_nx;
      r_we       <= w_we_nx;
      r_rd       <= w_rd_nx;
      r_cfg      <= w_cfg_nx;
      r_cnt      <= w_cnt_nx;
      r_clr_addr <= w_clr_addr_nx;
      r_last     <= w_last_nx;
      r_clr_done <= w_clr_done_nx;
    end
  end

  always_comb begin
    w_seq_nx   = r_state;
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    case (r_state)
      S_W4:    w_seq_nx = S_W2;
      S_W2:    w_seq_nx = S_W0;
      S_W0:    w_seq_nx = S_W1;
      S_W1:    w_seq_nx = S_R4;
      S_R4:    w_seq_nx = S_R2;
      S_R2:    w_seq_nx = S_R0;
      S_R0:    w_seq_nx = S_CLEAR;
      default: w_seq_nx = r_state;
    endcase
    case (r_state)
      S_WAIT_RDY: begin
        if (sdram_ready) begin
          w_state_nx = S_W4;
          w_phase_nx = PH_ISSUE;
        end
      end
      S_W4, S_W2, S_W0, S_W1, S_R4, S_R2, S_R0: begin
        case (r_phase)
          PH_ISSUE:  w_phase_nx = PH_SETTLE;
          PH_SETTLE: w_phase_nx = PH_WAIT;
          default: begin
            if (sdram_ready) begin
              w_state_nx = w_seq_nx;
              w_phase_nx = PH_ISSUE;
            end
          end
        endcase
      end
      S_CLEAR: begin
        if (w_expire && sdram_ready && r_last) w_state_nx = S_DONE;
      end
      default: w_state_nx = r_state;
    endcase
  end

  // Each command is launched from the cycle that sees the previous one complete.
  always_comb begin
    w_we_nx       = 1'b0;
    w_rd_nx       = 1'b0;
    w_addr_nx     = r_addr;
    w_din_nx      = r_din;
    w_cfg_nx      = r_cfg;
    w_cnt_nx      = r_cnt;
    w_clr_addr_nx = r_clr_addr;
    w_last_nx     = r_last;
    w_clr_done_nx = r_clr_done;
    case (r_state)
      S_WAIT_RDY: if (sdram_ready) begin
        w_we_nx = 1'b1; w_addr_nx = A4; w_din_nx = D4;
      end
      S_W4: if (w_acc_done) begin
        w_we_nx = 1'b1; w_addr_nx = A2; w_din_nx = D2;
      end
      S_W2: if (w_acc_done) begin
        w_we_nx = 1'b1; w_addr_nx = A0; w_din_nx = D0;
      end
      S_W0: if (w_acc_done) begin
        w_we_nx = 1'b1; w_addr_nx = A1; w_din_nx = D1;
      end
      S_W1: if (w_acc_done) begin
        w_rd_nx = 1'b1; w_addr_nx = A4;
      end
      S_R4: if (w_acc_done) begin
        w_cfg_nx[2] = (sdram_dout == D4);
        w_rd_nx = 1'b1; w_addr_nx = A2;
      end
      S_R2: if (w_acc_done) begin
        w_cfg_nx[1] = (sdram_dout == D2);
        w_rd_nx = 1'b1; w_addr_nx = A0;
      end
      S_R0: if (w_acc_done) begin
        w_cfg_nx[0]  = (sdram_dout == D0);
        w_cfg_nx[15] = 1'b1;
        w_cnt_nx     = 8'd0;
      end
      S_CLEAR: begin
        if (!w_expire) begin
          w_cnt_nx = r_cnt + 8'd1;
        end else if (sdram_ready) begin
          if (r_last) begin
            w_clr_done_nx = 1'b1;
          end else begin
            w_we_nx       = 1'b1;
            w_addr_nx     = 27'(r_clr_addr);
            w_din_nx      = 16'd0;
            w_clr_addr_nx = r_clr_addr + 1'b1;
            w_cnt_nx      = 8'd0;
            w_last_nx     = (r_clr_addr == '1);
          end
        end
      end
      default: ;
    endcase
  end

  assign sdram_addr = r_addr;
  assign sdram_din  = r_din;
  assign sdram_we   = r_we;
  assign sdram_rd   = r_rd;
  assign cfg        = r_cfg;
  assign clr_addr   = r_clr_addr;
  assign clr_done   = r_clr_done;

endmodule

// File: tb/tb_sdram_size_probe.sv
// Bench for sdram_size_probe: two instances (default and tiny sweep) driven by
// behavioural SDRAM controller models with configurable aliasing and latency.
module tb_sdram_size_probe;

  localparam logic [26:0] FULL = 27'h7FFFFFF;
  localparam logic [26:0] M64  = 27'h3FFFFFF;
  localparam logic [26:0] M32  = 27'h1FFFFFF;

  typedef struct {
    logic [26:0] mask;
    bit          rnd;
    bit          hold;
    logic [15:0] exp_cfg;
  } vec_t;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst_a, rst_b;
  logic        rdy_a = 1'b0, rdy_b = 1'b0;
  logic [15:0] dout_a = 16'h0, dout_b = 16'h0;
  logic [26:0] addr_a, addr_b;
  logic [15:0] din_a, din_b;
  logic        we_a, we_b, rd_a, rd_b;
  logic [15:0] cfg_a, cfg_b;
  logic [24:0] clr_addr_a;
  logic [3:0]  clr_addr_b;
  logic        clr_done_a, clr_done_b;

  sdram_size_probe dut_a (
    .clk_sys(clk_sys), .RESET(rst_a), .sdram_ready(rdy_a), .sdram_dout(dout_a),
    .sdram_addr(addr_a), .sdram_din(din_a), .sdram_we(we_a), .sdram_rd(rd_a),
    .cfg(cfg_a), .clr_addr(clr_addr_a), .clr_done(clr_done_a)
  );

  sdram_size_probe #(.CLR_AW(4), .CLR_GAP(4)) dut_b (
    .clk_sys(clk_sys), .RESET(rst_b), .sdram_ready(rdy_b), .sdram_dout(dout_b),
    .sdram_addr(addr_b), .sdram_din(din_b), .sdram_we(we_b), .sdram_rd(rd_b),
    .cfg(cfg_b), .clr_addr(clr_addr_b), .clr_done(clr_done_b)
  );

  // Controller model A: aliasing via mask, optional random latency and a long R2 stall.
  logic [26:0] mask_a = FULL;
  bit          rnd_a = 1'b0, hold_a = 1'b0;
  int          rem_a = 10;
  logic [15:0] rdat_a = 16'h0, rdat_b = 16'h0;
  logic [15:0] mem_a [8];
  logic [15:0] mem_b [8];
  logic [26:0] ma_a;
  assign ma_a = addr_a & mask_a;

  always @(posedge clk_sys) begin
    if (we_a || rd_a) begin
      rdy_a  <= 1'b0;
      dout_a <= 16'($urandom);
      if (we_a && ma_a[23:0] == 24'd0) mem_a[ma_a[26:24]] <= din_a;
      rdat_a <= (ma_a[23:0] == 24'd0) ? mem_a[ma_a[26:24]] : 16'h0;
      if (hold_a && rd_a && addr_a == 27'h2000000) rem_a <= 99;
      else rem_a <= rnd_a ? int'($urandom_range(0, 4)) : 0;
    end else if (!rdy_a) begin
      if (rem_a == 0) begin
        rdy_a  <= 1'b1;
        dout_a <= rdat_a;
      end else begin
        rem_a <= rem_a - 1;
      end
    end
  end

  always @(posedge clk_sys) begin
    if (we_b || rd_b) begin
      rdy_b <= 1'b0;
      if (we_b && addr_b[23:0] == 24'd0) mem_b[addr_b[26:24]] <= din_b;
      rdat_b <= (addr_b[23:0] == 24'd0) ? mem_b[addr_b[26:24]] : 16'h0;
    end else if (!rdy_b) begin
      rdy_b  <= 1'b1;
      dout_b <= rdat_b;
    end
  end

  int n_err = 0, n_chk = 0;
  int cyc = 0;
  int r2_cyc = 0, r0_cyc = 0, nstb_b = 0;
  int clrq_cyc[$];
  logic [26:0] clrq_addr[$];
  logic [26:0] bq[$];
  bit ok_g[2] = '{1'b0, 1'b0};
  int last_g[2] = '{-10, -10};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // A strobe is legal only after a ready seen at least two cycles past the previous strobe.
  task automatic proto(input int i, input logic we, input logic rd, input logic rdy);
    if (we || rd) begin
      chk(i == 0 ? "a_we_rd_excl" : "b_we_rd_excl", 32'(we & rd), 32'd0);
      chk(i == 0 ? "a_strobe_gate" : "b_strobe_gate", 32'(ok_g[i]), 32'd1);
      ok_g[i] = 1'b0;
      last_g[i] = cyc;
    end else if (rdy && cyc >= last_g[i] + 2) begin
      ok_g[i] = 1'b1;
    end
  endtask

  initial forever begin
    @(negedge clk_sys);
    cyc++;
    proto(0, we_a, rd_a, rdy_a);
    proto(1, we_b, rd_b, rdy_b);
    if (rd_a && addr_a == 27'h2000000) r2_cyc = cyc;
    if (rd_a && addr_a == 27'h0) r0_cyc = cyc;
    if (we_a && din_a == 16'h0) begin
      clrq_cyc.push_back(cyc);
      clrq_addr.push_back(addr_a);
    end
    if (we_b && din_b == 16'h0) bq.push_back(addr_b);
    if (we_b || rd_b) nstb_b++;
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  // Reference: write the four probe words into a sparse memory under the
  // module's address mask, then read the three probe locations back.
  function automatic logic [15:0] model_cfg(input logic [26:0] mask);
    logic [26:0] wa [4];
    logic [15:0] wd [4];
    logic [15:0] m [logic [26:0]];
    logic [15:0] r;
    wa[0] = 27'h4000000; wd[0] = 16'd3128;
    wa[1] = 27'h2000000; wd[1] = 16'd2064;
    wa[2] = 27'h0000000; wd[2] = 16'd1032;
    wa[3] = 27'h1000000; wd[3] = 16'd12345;
    for (int i = 0; i < 4; i++) m[wa[i] & mask] = wd[i];
    r = 16'h8000;
    for (int j = 0; j < 3; j++) r[2-j] = (m[wa[j] & mask] == wd[j]);
    return r;
  endfunction

  task automatic run_probe(input logic [26:0] mask, input bit rnd, input bit hold, output int lat);
    int t0, n;
    mask_a = mask; rnd_a = rnd; hold_a = hold;
    rst_a = 1'b1;
    tick(); tick();
    clrq_cyc.delete(); clrq_addr.delete();
    rst_a = 1'b0;
    t0 = rdy_a ? cyc : -1;
    n = 0;
    while (!cfg_a[15] && n < 3000) begin
      tick();
      n++;
      if (t0 < 0 && rdy_a) t0 = cyc;
    end
    chk("probe_complete", 32'(cfg_a[15]), 32'd1);
    lat = cyc - t0;
  endtask

  vec_t vecs[5];
  int   lat, n, n0;
  logic [26:0] msk;

  initial begin
    vecs[0] = '{FULL, 1'b0, 1'b0, 16'h8007};
    vecs[1] = '{M32,  1'b0, 1'b0, 16'h8001};
    vecs[2] = '{M64,  1'b0, 1'b0, 16'h8003};
    vecs[3] = '{FULL, 1'b0, 1'b1, 16'h8007};
    vecs[4] = '{M64,  1'b1, 1'b0, 16'h8003};

    rst_a = 1'b1; rst_b = 1'b1;
    tick(); tick();
    chk("reset_cfg", 32'(cfg_a), 32'h0);
    chk("reset_strobes", 32'({we_a, rd_a}), 32'h0);
    chk("reset_addr", 32'(addr_a), 32'h0);
    chk("reset_clr", 32'({clr_done_a, clr_addr_a}), 32'h0);
    tick();
    rst_b = 1'b0;

    // Tiny sweep: 16 writes, then silence.
    n = 0;
    while (!clr_done_b && n < 3000) begin tick(); n++; end
    chk("b_done", 32'(clr_done_b), 32'd1);
    chk("b_cfg", 32'(cfg_b), 32'h8007);
    chk("b_nwrites", 32'(bq.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < bq.size()) chk("b_clear_addr", 32'(bq[i]), 32'(i));
    chk("b_clr_addr_end", 32'(clr_addr_b), 32'd0);
    n0 = nstb_b;
    repeat (1000) tick();
    chk("b_no_strobes_after_done", 32'(nstb_b - n0), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_probe(vecs[i].mask, vecs[i].rnd, vecs[i].hold, lat);
      chk("cfg_vec", 32'(cfg_a), 32'(vecs[i].exp_cfg));
      if (vecs[i].hold) chk("r2_stall_r0_spacing", 32'(r0_cyc - r2_cyc), 32'd102);
      else if (!vecs[i].rnd) chk("probe_latency", 32'(lat), 32'd22);
      if (i == 0) begin
        n = 0;
        while (clrq_addr.size() < 4 && n < 1000) begin tick(); n++; end
        chk("clr_write_count", 32'(clrq_addr.size() >= 4), 32'd1);
        if (clrq_addr.size() >= 4) begin
          chk("clr_first_addr", 32'(clrq_addr[0]), 32'd0);
          chk("clr_second_addr", 32'(clrq_addr[1]), 32'd1);
          for (int j = 1; j < 4; j++)
            chk("clr_gap", 32'(clrq_cyc[j] - clrq_cyc[j-1]), 32'd32);
        end
        n = 0;
        while (clr_addr_a != 25'd5 && n < 2000) begin tick(); n++; end
        chk("reach_clr_addr5", 32'(clr_addr_a), 32'd5);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("midreset_cfg", 32'(cfg_a), 32'h0);
        chk("midreset_clr_addr", 32'(clr_addr_a), 32'h0);
        chk("midreset_strobes", 32'({we_a, rd_a}), 32'h0);
        chk("midreset_addr_din", 32'({addr_a[15:0], din_a}), 32'h0);
        n = 0;
        while (!cfg_a[15] && n < 3000) begin tick(); n++; end
        chk("cfg_after_midreset", 32'(cfg_a), 32'h8007);
      end
    end

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0:       msk = M32;
        1:       msk = M64;
        default: msk = FULL;
      endcase
      run_probe(msk, 1'b1, 1'b0, lat);
      chk("cfg_random", 32'(cfg_a), 32'(model_cfg(msk)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
